// File: rtl/dmem_responder.sv
// Single-port word-addressed data memory for the CPU dmem interface.
// Responses arrive after a programmable latency; err latches faulting requests.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_address,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [3:0]  mem_wmask,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_resp,
   output logic        err
);
   localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  CNT_LOAD  = 4'(LATENCY - 1);
   localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [29:0] idx_q, idx_d;
   logic [3:0]  wmask_q, wmask_d;
   logic [31:0] wdata_q, wdata_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic        resp_q, resp_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic        in_range_s;
   logic        fault_s;
   logic [31:0] rd_word_s;
   logic        wr_en_s;
   logic        addr_lsb_unused_s;

   assign addr_lsb_unused_s = ^mem_address[1:0];

   // Checks are made on the op about to enter RESP, so LATENCY=1 sees the live inputs.
   assign in_range_s = (idx_d < DEPTH_IDX);
   assign fault_s    = (rd_d && wr_d) || !in_range_s;
   assign rd_word_s  = in_range_s ? mem_q[idx_d[AW-1:0]] : 32'd0;
   assign wr_en_s    = (state_q == RESP) && wr_q && (idx_q < DEPTH_IDX);

   // Next-state, request latching and registered-output preparation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wmask_d = wmask_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      resp_d  = 1'b0;
      rdata_d = 32'd0;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (mem_read || mem_write) begin
               idx_d   = mem_address[31:2];
               wmask_d = mem_wmask;
               wdata_d = mem_wdata;
               rd_d    = mem_read;
               wr_d    = mem_write;
               cnt_d   = CNT_LOAD;
               if (LATENCY > 1) begin
                  state_d = WAIT;
               end else begin
                  state_d = RESP;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = RESP;
            end else begin
               state_d = WAIT;
            end
         end
         RESP: begin
            cnt_d   = 4'd0;
            state_d = IDLE;
         end
         default: begin
            cnt_d   = 4'd0;
            state_d = IDLE;
         end
      endcase
      if (state_d == RESP) begin
         resp_d = 1'b1;
         if (rd_d && !wr_d) begin
            rdata_d = rd_word_s;
         end else begin
            rdata_d = 32'd0;
         end
         if (fault_s) begin
            err_d = 1'b1;
         end else begin
            err_d = err_q;
         end
      end else begin
         resp_d = 1'b0;
      end
   end

   // Control state and registered outputs; reset abandons any pending request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= 30'd0;
         wmask_q <= 4'd0;
         wdata_q <= 32'd0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         resp_q  <= 1'b0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wmask_q <= wmask_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         resp_q  <= resp_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage keeps its contents through reset; writes land on the edge ending RESP.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         for (int b = 0; b < 4; b++) begin
            if (wmask_q[b]) begin
               mem_q[idx_q[AW-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
            end
         end
      end
   end

   assign mem_rdata = rdata_q;
   assign mem_resp  = resp_q;
   assign err       = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: three dmem_responder builds (LATENCY 2, 3, 1) against a
// word-array reference model with byte-mask merging and a sticky error flag.
module tb_dmem_responder;
   localparam int NI    = 3;
   localparam int DEPTH = 1024;
   localparam int LAT [NI] = '{2, 3, 1};

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr_s  [NI];
   logic        rd_s    [NI];
   logic        wr_s    [NI];
   logic [3:0]  mask_s  [NI];
   logic [31:0] wdata_s [NI];
   logic [31:0] rdata_s [NI];
   logic        resp_s  [NI];
   logic        err_s   [NI];

   logic [31:0] ref_mem [NI][DEPTH];
   logic        ref_err [NI];
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_l2 (
      .clk(clk), .rst(rst), .mem_address(addr_s[0]), .mem_read(rd_s[0]),
      .mem_write(wr_s[0]), .mem_wmask(mask_s[0]), .mem_wdata(wdata_s[0]),
      .mem_rdata(rdata_s[0]), .mem_resp(resp_s[0]), .err(err_s[0]));
   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_l3 (
      .clk(clk), .rst(rst), .mem_address(addr_s[1]), .mem_read(rd_s[1]),
      .mem_write(wr_s[1]), .mem_wmask(mask_s[1]), .mem_wdata(wdata_s[1]),
      .mem_rdata(rdata_s[1]), .mem_resp(resp_s[1]), .err(err_s[1]));
   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst), .mem_address(addr_s[2]), .mem_read(rd_s[2]),
      .mem_write(wr_s[2]), .mem_wmask(mask_s[2]), .mem_wdata(wdata_s[2]),
      .mem_rdata(rdata_s[2]), .mem_resp(resp_s[2]), .err(err_s[2]));

   // Reference behaviour of one completed request; returns the expected read data.
   function automatic void model_apply(input int k, input bit r, input bit w,
                                       input logic [31:0] a, input logic [3:0] m,
                                       input logic [31:0] d, output logic [31:0] exp_rd);
      logic [29:0] idx;
      bit          oor;
      idx    = a[31:2];
      oor    = (idx >= 30'd1024);
      exp_rd = 32'd0;
      if (r && !w && !oor) exp_rd = ref_mem[k][idx];
      if (w && !oor) begin
         for (int b = 0; b < 4; b++)
            if (m[b]) ref_mem[k][idx][8*b +: 8] = d[8*b +: 8];
      end
      if (oor || (r && w)) ref_err[k] = 1'b1;
   endfunction

   // One request held until mem_resp; lat is the cycle count, -1 if it never came.
   task automatic xact(input int k, input bit r, input bit w, input logic [31:0] a,
                       input logic [3:0] m, input logic [31:0] d, input bit scramble,
                       output int lat, output logic [31:0] rdv, output logic errv);
      lat  = -1;
      rdv  = 32'd0;
      errv = 1'b0;
      @(negedge clk);
      addr_s[k] = a; rd_s[k] = r; wr_s[k] = w; mask_s[k] = m; wdata_s[k] = d;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (resp_s[k] === 1'b1) begin
            lat = c; rdv = rdata_s[k]; errv = err_s[k];
            break;
         end
         if (scramble) begin
            addr_s[k] = $urandom; rd_s[k] = 1'($urandom); wr_s[k] = 1'($urandom);
            mask_s[k] = 4'($urandom); wdata_s[k] = $urandom;
         end
      end
      rd_s[k] = 1'b0;
      wr_s[k] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int k = 0; k < NI; k++) begin
         addr_s[k] = 32'd0; rd_s[k] = 1'b0; wr_s[k] = 1'b0; mask_s[k] = 4'd0; wdata_s[k] = 32'd0;
         ref_err[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         n_checks++; if (resp_s[k] !== 1'b0) begin n_fail++; $display("FAIL reset_resp k=%0d: got %b expected 0", k, resp_s[k]); end
         n_checks++; if (rdata_s[k] !== 32'd0) begin n_fail++; $display("FAIL reset_rdata k=%0d: got %h expected 0", k, rdata_s[k]); end
         n_checks++; if (err_s[k] !== 1'b0) begin n_fail++; $display("FAIL reset_err k=%0d: got %b expected 0", k, err_s[k]); end
      end
      rst = 1'b1;
   endtask

   task automatic test_preload();
      logic [31:0] d, e, rv; logic ev; int lat;
      for (int k = 0; k < NI; k++)
         for (int i = 0; i < 16; i++) begin
            d = $urandom;
            model_apply(k, 1'b0, 1'b1, 32'(i * 4), 4'hF, d, e);
            xact(k, 1'b0, 1'b1, 32'(i * 4), 4'hF, d, 1'b0, lat, rv, ev);
            n_checks++; if (lat != LAT[k]) begin n_fail++; $display("FAIL preload_lat k=%0d: got %0d expected %0d", k, lat, LAT[k]); end
         end
   endtask

   task automatic test_basic();
      logic [31:0] e, rv; logic ev; int lat;
      for (int k = 0; k < NI; k++) begin
         model_apply(k, 1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, e);
         xact(k, 1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, lat, rv, ev);
         n_checks++; if (lat != LAT[k] || ev !== 1'b0) begin n_fail++; $display("FAIL basic_wr k=%0d: got lat %0d err %b expected lat %0d err 0", k, lat, ev, LAT[k]); end
         model_apply(k, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, e);
         xact(k, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, lat, rv, ev);
         n_checks++; if (lat != LAT[k] || rv !== 32'hDEADBEEF || ev !== 1'b0) begin n_fail++; $display("FAIL basic_rd k=%0d: got lat %0d data %h err %b expected lat %0d data deadbeef err 0", k, lat, rv, ev, LAT[k]); end
         model_apply(k, 1'b0, 1'b1, 32'h10, 4'b0010, 32'h0000AA00, e);
         xact(k, 1'b0, 1'b1, 32'h10, 4'b0010, 32'h0000AA00, 1'b0, lat, rv, ev);
         model_apply(k, 1'b1, 1'b0, 32'h12, 4'h0, 32'h0, e);
         xact(k, 1'b1, 1'b0, 32'h12, 4'h0, 32'h0, 1'b0, lat, rv, ev);
         n_checks++; if (rv !== 32'hDEADAAEF || ev !== 1'b0) begin n_fail++; $display("FAIL basic_mask k=%0d: got data %h err %b expected deadaaef err 0", k, rv, ev); end
         model_apply(k, 1'b0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, e);
         xact(k, 1'b0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 1'b0, lat, rv, ev);
         xact(k, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, lat, rv, ev);
         n_checks++; if (rv !== 32'hDEADAAEF || ev !== 1'b0) begin n_fail++; $display("FAIL basic_mask0 k=%0d: got data %h err %b expected deadaaef err 0", k, rv, ev); end
      end
   endtask

   task automatic test_hold(input int k);
      int l, last;
      logic [31:0] expv;
      bit exp_resp;
      l    = LAT[k];
      last = l + 2 * (l + 1);
      expv = ref_mem[k][4];
      @(negedge clk);
      addr_s[k] = 32'h10; rd_s[k] = 1'b1; wr_s[k] = 1'b0;
      for (int c = 1; c <= last; c++) begin
         @(posedge clk);
         @(negedge clk);
         exp_resp = (c >= l) && (((c - l) % (l + 1)) == 0);
         n_checks++; if (resp_s[k] !== exp_resp) begin n_fail++; $display("FAIL hold_resp k=%0d c=%0d: got %b expected %b", k, c, resp_s[k], exp_resp); end
         n_checks++; if (rdata_s[k] !== (exp_resp ? expv : 32'd0)) begin n_fail++; $display("FAIL hold_rdata k=%0d c=%0d: got %h expected %h", k, c, rdata_s[k], exp_resp ? expv : 32'd0); end
      end
      rd_s[k] = 1'b0;
   endtask

   task automatic test_scramble();
      logic [31:0] a, d, e, rv; logic ev; int lat;
      for (int k = 0; k < NI; k++)
         for (int i = 0; i < 4; i++) begin
            a = 32'($urandom_range(0, 63));
            d = $urandom;
            model_apply(k, 1'b0, 1'b1, a, 4'hF, d, e);
            xact(k, 1'b0, 1'b1, a, 4'hF, d, 1'b1, lat, rv, ev);
            a = 32'($urandom_range(0, 63));
            model_apply(k, 1'b1, 1'b0, a, 4'h0, 32'h0, e);
            xact(k, 1'b1, 1'b0, a, 4'h0, 32'h0, 1'b1, lat, rv, ev);
            n_checks++; if (lat != LAT[k] || rv !== e || ev !== ref_err[k]) begin n_fail++; $display("FAIL scramble k=%0d: got lat %0d data %h err %b expected lat %0d data %h err %b", k, lat, rv, ev, LAT[k], e, ref_err[k]); end
         end
   endtask

   task automatic test_rw_both();
      logic [31:0] e, rv; logic ev; int lat;
      for (int k = 0; k < NI; k++) begin
         model_apply(k, 1'b1, 1'b1, 32'h20, 4'hF, 32'h12345678, e);
         xact(k, 1'b1, 1'b1, 32'h20, 4'hF, 32'h12345678, 1'b0, lat, rv, ev);
         n_checks++; if (lat != LAT[k] || rv !== 32'd0 || ev !== 1'b1) begin n_fail++; $display("FAIL rw_both k=%0d: got lat %0d data %h err %b expected lat %0d data 0 err 1", k, lat, rv, ev, LAT[k]); end
         model_apply(k, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, e);
         xact(k, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, lat, rv, ev);
         n_checks++; if (rv !== 32'h12345678) begin n_fail++; $display("FAIL rw_both_rd k=%0d: got %h expected 12345678", k, rv); end
      end
   endtask

   task automatic test_oor();
      logic [31:0] e, rv; logic ev; int lat;
      for (int k = 0; k < NI; k++) begin
         model_apply(k, 1'b0, 1'b1, 32'h1000, 4'hF, 32'hA5A5A5A5, e);
         xact(k, 1'b0, 1'b1, 32'h1000, 4'hF, 32'hA5A5A5A5, 1'b0, lat, rv, ev);
         n_checks++; if (lat != LAT[k] || ev !== 1'b1) begin n_fail++; $display("FAIL oor_wr k=%0d: got lat %0d err %b expected lat %0d err 1", k, lat, ev, LAT[k]); end
         model_apply(k, 1'b1, 1'b0, 32'h1000, 4'h0, 32'h0, e);
         xact(k, 1'b1, 1'b0, 32'h1000, 4'h0, 32'h0, 1'b0, lat, rv, ev);
         n_checks++; if (lat != LAT[k] || rv !== 32'd0 || ev !== 1'b1) begin n_fail++; $display("FAIL oor_rd k=%0d: got lat %0d data %h err %b expected lat %0d data 0 err 1", k, lat, rv, ev, LAT[k]); end
         model_apply(k, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, e);
         xact(k, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, lat, rv, ev);
         n_checks++; if (rv !== e || ev !== 1'b1) begin n_fail++; $display("FAIL oor_sticky k=%0d: got data %h err %b expected data %h err 1", k, rv, ev, e); end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, d, e, rv; logic [3:0] m; logic ev; int lat, op; bit r, w;
      for (int k = 0; k < NI; k++)
         for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 9);
            r  = (op <= 4) || (op == 8);
            w  = (op >= 5);
            a  = (op == 9) ? (32'h1000 + 32'($urandom_range(0, 4095))) : 32'($urandom_range(0, 63));
            m  = 4'($urandom);
            d  = $urandom;
            model_apply(k, r, w, a, m, d, e);
            xact(k, r, w, a, m, d, 1'b0, lat, rv, ev);
            n_checks++; if (lat != LAT[k] || rv !== e || ev !== ref_err[k]) begin n_fail++; $display("FAIL random k=%0d op=%0d a=%h: got lat %0d data %h err %b expected lat %0d data %h err %b", k, op, a, lat, rv, ev, LAT[k], e, ref_err[k]); end
         end
   endtask

   task automatic test_reset_mid(input int k);
      logic [31:0] prior, rv; logic ev; int lat;
      prior = ref_mem[k][12];
      @(negedge clk);
      addr_s[k] = 32'h30; rd_s[k] = 1'b0; wr_s[k] = 1'b1; mask_s[k] = 4'hF; wdata_s[k] = 32'hCAFEF00D;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++; if (resp_s[k] !== 1'b0 || err_s[k] !== 1'b0) begin n_fail++; $display("FAIL rstmid_resp k=%0d c=%0d: got resp %b err %b expected 0 0", k, c, resp_s[k], err_s[k]); end
         @(negedge clk);
      end
      wr_s[k] = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < NI; i++) ref_err[i] = 1'b0;
      xact(k, 1'b1, 1'b0, 32'h30, 4'h0, 32'h0, 1'b0, lat, rv, ev);
      n_checks++; if (lat != LAT[k] || rv !== prior || ev !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd k=%0d: got lat %0d data %h err %b expected lat %0d data %h err 0", k, lat, rv, ev, LAT[k], prior); end
   endtask

   initial begin
      test_reset();
      test_preload();
      test_basic();
      for (int k = 0; k < NI; k++) test_hold(k);
      test_scramble();
      test_rw_both();
      test_oor();
      test_random();
      test_reset_mid(0);
      test_reset_mid(1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
